memory_access: RTL and testbench

Memory stage of the 5-stage RISC-V pipeline. It consumes the fields held by the EX/MEM pipeline register, resolves branches/jumps, and performs loads/stores on an internal word-addressed data memory with a configurable number of wait states. While an access is in progress it stalls the upstream stages. Results land in a built-in MEM/WB output register feeding write-back.

---
 rtl/memory_access.sv | 111 +++++++++++
 tb/tb_memory_access.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory stage of the 5-stage RISC-V pipeline: branch/jump resolution, wait-stated
// loads/stores on a word-addressed data memory, and the MEM/WB output register.
module memory_access #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  exmem_ctrl,
  input  logic        exmem_zero,
  input  logic [7:0]  exmem_pc_jump,
  input  logic [31:0] exmem_addr,
  input  logic [31:0] exmem_wr_data,
  input  logic [4:0]  exmem_rd,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [7:0]  pc_target,
  output logic        flush,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic        wb_fault
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [2:0]  WS      = 3'(WAIT_STATES);
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_access;
  logic          w_store;
  logic          w_load;
  logic          w_misaligned;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_load_data;
  logic          w_unused_addr;

  assign w_access      = exmem_ctrl[2] | exmem_ctrl[3];
  assign w_store       = exmem_ctrl[3];
  // A simultaneous read+write request behaves as a plain store
  assign w_load        = exmem_ctrl[2] & ~exmem_ctrl[3];
  assign w_misaligned  = (exmem_addr[1:0] != 2'b00);
  assign w_idx         = exmem_addr[AW+1:2];
  assign w_unused_addr = ^exmem_addr[31:AW+2];
  assign w_load_data   = (w_load && !w_misaligned) ? r_mem[w_idx] : 32'h0;

  assign w_commit  = (r_state == IDLE) ? (!w_access || NO_WAIT) : (r_cnt == 3'd1);
  assign mem_stall = (r_state == IDLE) ? (w_access && !NO_WAIT) : (r_cnt != 3'd1);

  assign pc_src    = exmem_ctrl[5] | (exmem_ctrl[4] & exmem_zero);
  assign flush     = pc_src;
  assign pc_target = exmem_pc_jump;

  // Access sequencing and MEM/WB register; stalled edges insert a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 3'd0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= 32'h0;
      wb_alu_result <= 32'h0;
      wb_rd         <= 5'd0;
      wb_fault      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && !NO_WAIT) begin
            r_state <= BUSY;
            r_cnt   <= WS;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_commit) begin
        wb_reg_write  <= exmem_ctrl[0];
        wb_mem_to_reg <= exmem_ctrl[1];
        wb_read_data  <= w_load_data;
        wb_alu_result <= exmem_addr;
        wb_rd         <= exmem_rd;
        wb_fault      <= w_access & w_misaligned;
      end else begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_read_data  <= 32'h0;
        wb_alu_result <= 32'h0;
        wb_rd         <= 5'd0;
        wb_fault      <= 1'b0;
      end
    end
  end

  // Data memory keeps its contents across reset; a store pending at reset is lost
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_store && !w_misaligned) r_mem[w_idx] <= exmem_wr_data;
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: two instances (2 and 0 wait states) driven by directed
// and random instructions, compared against a word-array reference model.
module tb_memory_access;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic        flush;
    logic [7:0]  pct;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        fault;
  } snap_t;

  logic clk = 1'b0;
  logic reset;

  logic [5:0]  ctrl  [2];
  logic        zero  [2];
  logic [7:0]  pcj   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [4:0]  rd    [2];

  logic        a_stall, a_pc_src, a_flush, a_rw, a_m2r, a_fault;
  logic [7:0]  a_pct;
  logic [31:0] a_rdata, a_alu;
  logic [4:0]  a_rd;
  logic        b_stall, b_pc_src, b_flush, b_rw, b_m2r, b_fault;
  logic [7:0]  b_pct;
  logic [31:0] b_rdata, b_alu;
  logic [4:0]  b_rd;

  logic [31:0] model [2][DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_access #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(reset),
    .exmem_ctrl(ctrl[0]), .exmem_zero(zero[0]), .exmem_pc_jump(pcj[0]),
    .exmem_addr(addr[0]), .exmem_wr_data(wdata[0]), .exmem_rd(rd[0]),
    .mem_stall(a_stall), .pc_src(a_pc_src), .pc_target(a_pct), .flush(a_flush),
    .wb_reg_write(a_rw), .wb_mem_to_reg(a_m2r), .wb_read_data(a_rdata),
    .wb_alu_result(a_alu), .wb_rd(a_rd), .wb_fault(a_fault)
  );

  memory_access #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset),
    .exmem_ctrl(ctrl[1]), .exmem_zero(zero[1]), .exmem_pc_jump(pcj[1]),
    .exmem_addr(addr[1]), .exmem_wr_data(wdata[1]), .exmem_rd(rd[1]),
    .mem_stall(b_stall), .pc_src(b_pc_src), .pc_target(b_pct), .flush(b_flush),
    .wb_reg_write(b_rw), .wb_mem_to_reg(b_m2r), .wb_read_data(b_rdata),
    .wb_alu_result(b_alu), .wb_rd(b_rd), .wb_fault(b_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int d, output snap_t s);
    if (d == 0) begin
      s.stall = a_stall; s.pc_src = a_pc_src; s.flush = a_flush; s.pct = a_pct;
      s.rw = a_rw; s.m2r = a_m2r; s.rdata = a_rdata; s.alu = a_alu; s.rd = a_rd; s.fault = a_fault;
    end else begin
      s.stall = b_stall; s.pc_src = b_pc_src; s.flush = b_flush; s.pct = b_pct;
      s.rw = b_rw; s.m2r = b_m2r; s.rdata = b_rdata; s.alu = b_alu; s.rd = b_rd; s.fault = b_fault;
    end
  endtask

  task automatic check_bubble(input int d, input string tag);
    snap_t s;
    sample(d, s);
    check({tag, "_bubble_ctl"}, 32'({s.rw, s.m2r, s.fault, s.rd}), 32'h0);
    check({tag, "_bubble_data"}, s.rdata | s.alu, 32'h0);
  endtask

  // Runs one instruction on instance d from issue to commit; entered and left at posedge+1
  task automatic do_op(input int d, input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r, input logic z,
                       input logic [7:0] pj, input string tag);
    snap_t s;
    int ws, lat, idx;
    bit access, store, load, mis, redirect;
    logic [31:0] exp_rdata;
    ws       = (d == 0) ? 2 : 0;
    access   = c[2] || c[3];
    store    = c[3];
    load     = c[2] && !c[3];
    mis      = (a % 4) != 0;
    redirect = c[5] || (c[4] && z);
    lat      = access ? ws + 1 : 1;
    idx      = int'((a / 4) % DEPTH);
    ctrl[d] = c; addr[d] = a; wdata[d] = wd; rd[d] = r; zero[d] = z; pcj[d] = pj;
    #1;
    for (int cyc = 0; cyc < lat; cyc++) begin
      sample(d, s);
      check({tag, "_stall"}, 32'(s.stall), 32'(access && cyc < ws));
      check({tag, "_pc_src"}, 32'(s.pc_src), 32'(redirect));
      check({tag, "_flush"}, 32'(s.flush), 32'(redirect));
      check({tag, "_pc_target"}, 32'(s.pct), 32'(pj));
      @(posedge clk); #1;
      if (cyc < lat - 1) check_bubble(d, tag);
    end
    exp_rdata = (load && !mis) ? model[d][idx] : 32'h0;
    if (store && !mis) model[d][idx] = wd;
    sample(d, s);
    check({tag, "_wb_ctl"}, 32'({s.rw, s.m2r}), 32'({c[0], c[1]}));
    check({tag, "_wb_rdata"}, s.rdata, exp_rdata);
    check({tag, "_wb_alu"}, s.alu, a);
    check({tag, "_wb_rd"}, 32'(s.rd), 32'(r));
    check({tag, "_wb_fault"}, 32'(s.fault), 32'(access && mis));
    ctrl[d] = 6'h0;
  endtask

  localparam logic [5:0] C_ALU   = 6'b000001;
  localparam logic [5:0] C_LOAD  = 6'b000111;
  localparam logic [5:0] C_STORE = 6'b001000;
  localparam logic [5:0] C_BOTH  = 6'b001100;
  localparam logic [5:0] C_BR    = 6'b010000;
  localparam logic [5:0] C_JMP   = 6'b100000;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    snap_t s;
    logic [5:0]  rc;
    logic [31:0] ra;
    int d;
    for (int k = 0; k < 2; k++) begin
      ctrl[k] = '0; zero[k] = 1'b0; pcj[k] = '0; addr[k] = '0; wdata[k] = '0; rd[k] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_bubble(k, "reset");
      sample(k, s);
      check("reset_stall", 32'(s.stall), 32'h0);
    end
    reset = 1'b0;

    // Fill both memories with known random data
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++)
        do_op(k, C_STORE, 32'(i * 4), $urandom(), 5'(i), 1'b0, 8'h0, "init");

    do_op(0, C_STORE, 32'h40, 32'h12345678, 5'd3, 1'b0, 8'h0, "st40");
    do_op(0, C_LOAD, 32'h40, 32'h0, 5'd9, 1'b0, 8'h0, "ld40");
    check("ld40_value", a_rdata, 32'h12345678);

    do_op(1, C_ALU, 32'h7, 32'h0, 5'd5, 1'b0, 8'h0, "ws0_alu");
    do_op(1, C_LOAD, 32'h40, 32'h0, 5'd6, 1'b0, 8'h0, "ws0_ld");

    do_op(0, C_BR, 32'h0, 32'h0, 5'd0, 1'b1, 8'h24, "br_taken");
    do_op(0, C_BR, 32'h0, 32'h0, 5'd0, 1'b0, 8'h24, "br_not");
    do_op(0, C_JMP, 32'h0, 32'h0, 5'd0, 1'b0, 8'h30, "jump");

    do_op(0, C_STORE, 32'h41, 32'hFFFFFFFF, 5'd0, 1'b0, 8'h0, "mis_st");
    do_op(0, C_LOAD, 32'h40, 32'h0, 5'd4, 1'b0, 8'h0, "mis_ld");
    check("mis_unchanged", a_rdata, 32'h12345678);

    do_op(0, C_STORE, 32'h400, 32'hCAFEF00D, 5'd0, 1'b0, 8'h0, "wrap_st");
    do_op(0, C_LOAD, 32'h0, 32'h0, 5'd2, 1'b0, 8'h0, "wrap_ld");
    check("wrap_value", a_rdata, 32'hCAFEF00D);

    do_op(0, C_BOTH, 32'h80, 32'hA5A5A5A5, 5'd1, 1'b0, 8'h0, "rw_both");

    // Store dropped by reset in its second busy cycle
    do_op(0, C_STORE, 32'h10, 32'h11111111, 5'd0, 1'b0, 8'h0, "pre_st");
    ctrl[0] = C_STORE; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; ctrl[0] = 6'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_bubble(0, "mid_reset");
    sample(0, s);
    check("mid_reset_stall", 32'(s.stall), 32'h0);
    do_op(0, C_LOAD, 32'h10, 32'h0, 5'd7, 1'b0, 8'h0, "post_rst_ld");
    check("post_rst_value", a_rdata, 32'h11111111);

    for (int n = 0; n < 400; n++) begin
      d  = int'($urandom_range(0, 1));
      ra = $urandom();
      if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0:       rc = C_ALU;
        1, 2:    rc = C_LOAD;
        3:       rc = C_STORE;
        4:       rc = C_BOTH;
        default: rc = ($urandom_range(0, 1) != 0) ? C_BR : C_JMP;
      endcase
      do_op(d, rc, ra, $urandom(), 5'($urandom()), 1'($urandom()), 8'($urandom()), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
